// File: rtl/mips_defs.sv
// Purpose : shared encodings for the MIPS controllers (opcodes, functs, ALU codes, mux selects, FSM states).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mips_defs;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_SEXT  = 2'b10;
  localparam logic [1:0] ALUB_SEXT2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADR  = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_J        = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Purpose : maps an R-type funct field to an ALU control code; unknown functs fall back to add and flag illegal.
// Latency : combinational, zero cycles.
// Backpressure: none.
// Ports   : funct (IR[5:0]) -> alu_ctrl[2:0], illegal_funct.
module mips_alu_decoder
  import mips_defs::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       illegal_funct
);

  always_comb begin
    alu_ctrl      = ALU_ADD;
    illegal_funct = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : Moore FSM sequencing the multicycle MIPS datapath (fetch/decode/execute/memory/writeback) and counting retirements.
// Latency : lw 5 cycles; R-type/addi/slti/sw 4; beq/j/jal/jr 3; plus one cycle per mem_ready=0 cycle in a memory state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their state until mem_ready is high.
// Ports   : clk, rst (async active-high); opcode/funct from IR, zero from ALU, mem_ready from memory;
//           datapath selects/enables out, illegal pulse, instret retired-instruction counter.
module mips_multicycle_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             jal_ctrl,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] funct_alu;
  logic       funct_ill;
  logic       retire;

  mips_alu_decoder u_alu_dec (
    .funct         (funct),
    .alu_ctrl      (funct_alu),
    .illegal_funct (funct_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    jal_ctrl   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_B;
    alu_ctrl   = ALU_AND;
    pc_src     = PCSRC_ALU;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        alu_ctrl  = ALU_ADD;
        // IR and PC+4 are only captured on the cycle the read completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding
        alu_src_b = ALUB_SEXT2;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE:      state_nxt = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADR;
          OP_BEQ:        state_nxt = S_BEQ;
          OP_ADDI,
          OP_SLTI:       state_nxt = S_IMM_EX;
          OP_J:          state_nxt = S_J;
          OP_JAL:        state_nxt = S_JAL;
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SEXT;
        alu_ctrl  = ALU_ADD;
        state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_B;
        alu_ctrl  = funct_alu;
        // Unknown funct is flagged but still completes as an add
        illegal   = funct_ill;
        state_nxt = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_B;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
        state_nxt = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SEXT;
        alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_nxt = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_J: begin
        pc_src    = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // Register file writes PC (already PC+4) into r31
        pc_src    = PCSRC_JUMP;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        jal_ctrl  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JR: begin
        pc_src    = PCSRC_RS;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset kills every side effect immediately, even mid-instruction
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  // DECODE only returns to FETCH on an illegal opcode, which does not retire
  assign retire = (state != S_FETCH) && (state != S_DECODE) && (state_nxt == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : directed, self-checking bench for mips_multicycle_ctrl using an expected-value queue.
// Latency : each step drives one cycle of inputs and compares all outputs plus instret at the falling edge.
// Backpressure: mem_ready is driven low in FETCH/MEM_RD/MEM_WR steps to exercise wait states.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       jal_ctrl;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] ret;
  } exp_t;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic        mem_to_reg, jal_ctrl, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] instret;

  ctl_t        obs;
  exp_t        exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] n_ret = '0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .jal_ctrl(jal_ctrl),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .pc_src(pc_src), .illegal(illegal), .instret(instret)
  );

  assign obs = '{pc_write: pc_write, i_or_d: i_or_d, mem_read: mem_read, mem_write: mem_write,
                 ir_write: ir_write, reg_dst: reg_dst, mem_to_reg: mem_to_reg, jal_ctrl: jal_ctrl,
                 reg_write: reg_write, alu_src_a: alu_src_a, alu_src_b: alu_src_b,
                 alu_ctrl: alu_ctrl, pc_src: pc_src, illegal: illegal};

  // Expected per-state output vectors, written straight from the state descriptions
  function automatic ctl_t e_reset();
    ctl_t c = '0;
    c.alu_src_b = 2'b01; c.alu_ctrl = A_ADD;
    return c;
  endfunction
  function automatic ctl_t e_fetch(input logic mr);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = A_ADD;
    c.ir_write = mr; c.pc_write = mr;
    return c;
  endfunction
  function automatic ctl_t e_decode(input logic ill);
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.alu_ctrl = A_ADD; c.illegal = ill;
    return c;
  endfunction
  function automatic ctl_t e_memadr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = A_ADD;
    return c;
  endfunction
  function automatic ctl_t e_memrd();
    ctl_t c = '0;
    c.mem_read = 1'b1; c.i_or_d = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_memwb();
    ctl_t c = '0;
    c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_memwr();
    ctl_t c = '0;
    c.mem_write = 1'b1; c.i_or_d = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_rex(input logic [2:0] alu, input logic ill);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_ctrl = alu; c.illegal = ill;
    return c;
  endfunction
  function automatic ctl_t e_rwb();
    ctl_t c = '0;
    c.reg_dst = 1'b1; c.reg_write = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_beq(input logic z);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_ctrl = A_SUB; c.pc_src = 2'b01; c.pc_write = z;
    return c;
  endfunction
  function automatic ctl_t e_iex(input logic [2:0] alu);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = alu;
    return c;
  endfunction
  function automatic ctl_t e_iwb();
    ctl_t c = '0;
    c.reg_write = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_jump(input logic [1:0] src, input logic link);
    ctl_t c = '0;
    c.pc_src = src; c.pc_write = 1'b1; c.reg_write = link; c.jal_ctrl = link;
    return c;
  endfunction

  task automatic check_front();
    exp_t  x;
    string t;
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert ({obs, instret} === x)
    else begin
      n_err++;
      $error("FAIL %s: observed ctl=%h instret=%0d expected ctl=%h instret=%0d",
             t, obs, instret, x.ctl, x.ret);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue the expectation, compare at the falling edge
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr,
                      input ctl_t e, input string tag);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    exp_q.push_back('{ctl: e, ret: n_ret});
    tag_q.push_back(tag);
    @(negedge clk);
    check_front();
  endtask

  initial begin
    logic [5:0] rfn [4];
    logic [2:0] ralu[4];
    rfn  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ralu = '{A_SUB, A_AND, A_OR, A_SLT};

    // Reset held: enables forced low even though mem_ready is high in FETCH
    #2;
    exp_q.push_back('{ctl: e_reset(), ret: 32'd0}); tag_q.push_back("reset_state");
    check_front();
    mem_ready = 1'b0;
    #15 rst = 1'b0;

    // add: 4 cycles, write-back only in the last
    step(6'b000000, 6'b100000, 0, 1, e_fetch(1),        "add_fetch");
    step(6'b000000, 6'b100000, 0, 1, e_decode(0),       "add_decode");
    step(6'b000000, 6'b100000, 0, 1, e_rex(A_ADD, 0),   "add_ex");
    step(6'b000000, 6'b100000, 0, 1, e_rwb(),           "add_wb");
    n_ret++;

    // lw with two wait cycles in MEM_RD: 7 cycles
    step(6'b100011, 6'b000000, 0, 1, e_fetch(1),        "lw_fetch");
    step(6'b100011, 6'b000000, 0, 1, e_decode(0),       "lw_decode");
    step(6'b100011, 6'b000000, 0, 1, e_memadr(),        "lw_adr");
    step(6'b100011, 6'b000000, 0, 0, e_memrd(),         "lw_rd_wait1");
    step(6'b100011, 6'b000000, 0, 0, e_memrd(),         "lw_rd_wait2");
    step(6'b100011, 6'b000000, 0, 1, e_memrd(),         "lw_rd_done");
    step(6'b100011, 6'b000000, 0, 1, e_memwb(),         "lw_wb");
    n_ret++;

    // sw, no waits: 4 cycles
    step(6'b101011, 6'b000000, 0, 1, e_fetch(1),        "sw_fetch");
    step(6'b101011, 6'b000000, 0, 1, e_decode(0),       "sw_decode");
    step(6'b101011, 6'b000000, 0, 1, e_memadr(),        "sw_adr");
    step(6'b101011, 6'b000000, 0, 1, e_memwr(),         "sw_wr");
    n_ret++;

    // sw abandoned by reset while MEM_WR waits
    step(6'b101011, 6'b000000, 0, 1, e_fetch(1),        "swr_fetch");
    step(6'b101011, 6'b000000, 0, 1, e_decode(0),       "swr_decode");
    step(6'b101011, 6'b000000, 0, 1, e_memadr(),        "swr_adr");
    step(6'b101011, 6'b000000, 0, 0, e_memwr(),         "swr_wr_wait");
    #2 rst = 1'b1;
    #1;
    n_ret = '0;
    exp_q.push_back('{ctl: e_reset(), ret: 32'd0}); tag_q.push_back("reset_mid_memwr");
    check_front();
    @(negedge clk);
    rst = 1'b0;

    // First cycle after release is FETCH (still waiting)
    step(6'b000100, 6'b000000, 1, 0, e_fetch(0),        "post_reset_fetch");

    // beq taken
    step(6'b000100, 6'b000000, 1, 1, e_fetch(1),        "beqt_fetch");
    step(6'b000100, 6'b000000, 1, 1, e_decode(0),       "beqt_decode");
    step(6'b000100, 6'b000000, 1, 1, e_beq(1),          "beqt_branch");
    n_ret++;

    // beq not taken, with one fetch wait state
    step(6'b000100, 6'b000000, 0, 0, e_fetch(0),        "beqn_fetch_wait");
    step(6'b000100, 6'b000000, 0, 1, e_fetch(1),        "beqn_fetch");
    step(6'b000100, 6'b000000, 0, 1, e_decode(0),       "beqn_decode");
    step(6'b000100, 6'b000000, 0, 1, e_beq(0),          "beqn_branch");
    n_ret++;

    // jal, jr, j
    step(6'b000011, 6'b000000, 0, 1, e_fetch(1),        "jal_fetch");
    step(6'b000011, 6'b000000, 0, 1, e_decode(0),       "jal_decode");
    step(6'b000011, 6'b000000, 0, 1, e_jump(2'b10, 1),  "jal_jump");
    n_ret++;
    step(6'b000000, 6'b001000, 0, 1, e_fetch(1),        "jr_fetch");
    step(6'b000000, 6'b001000, 0, 1, e_decode(0),       "jr_decode");
    step(6'b000000, 6'b001000, 0, 1, e_jump(2'b11, 0),  "jr_jump");
    n_ret++;
    step(6'b000010, 6'b000000, 0, 1, e_fetch(1),        "j_fetch");
    step(6'b000010, 6'b000000, 0, 1, e_decode(0),       "j_decode");
    step(6'b000010, 6'b000000, 0, 1, e_jump(2'b10, 0),  "j_jump");
    n_ret++;

    // Illegal opcode: pulse in DECODE, back to FETCH, not counted
    step(6'b111111, 6'b000000, 0, 1, e_fetch(1),        "ill_fetch");
    step(6'b111111, 6'b000000, 0, 1, e_decode(1),       "ill_decode");

    // Unknown funct: flagged in execute, completes as add and retires
    step(6'b000000, 6'b000111, 0, 1, e_fetch(1),        "badfn_fetch");
    step(6'b000000, 6'b000111, 0, 1, e_decode(0),       "badfn_decode");
    step(6'b000000, 6'b000111, 0, 1, e_rex(A_ADD, 1),   "badfn_ex");
    step(6'b000000, 6'b000111, 0, 1, e_rwb(),           "badfn_wb");
    n_ret++;

    // Remaining R-type ALU operations
    for (int i = 0; i < 4; i++) begin
      step(6'b000000, rfn[i], 0, 1, e_fetch(1),         "rt_fetch");
      step(6'b000000, rfn[i], 0, 1, e_decode(0),        "rt_decode");
      step(6'b000000, rfn[i], 1, 1, e_rex(ralu[i], 0),  "rt_ex");
      step(6'b000000, rfn[i], 0, 1, e_rwb(),            "rt_wb");
      n_ret++;
    end

    // Immediate forms
    step(6'b001000, 6'b000000, 0, 1, e_fetch(1),        "addi_fetch");
    step(6'b001000, 6'b000000, 0, 1, e_decode(0),       "addi_decode");
    step(6'b001000, 6'b000000, 0, 1, e_iex(A_ADD),      "addi_ex");
    step(6'b001000, 6'b000000, 0, 1, e_iwb(),           "addi_wb");
    n_ret++;
    step(6'b001010, 6'b000000, 0, 1, e_fetch(1),        "slti_fetch");
    step(6'b001010, 6'b000000, 0, 1, e_decode(0),       "slti_decode");
    step(6'b001010, 6'b000000, 0, 1, e_iex(A_SLT),      "slti_ex");
    step(6'b001010, 6'b000000, 0, 1, e_iwb(),           "slti_wb");
    n_ret++;

    // Final count visible in an idle FETCH
    step(6'b000000, 6'b000000, 0, 0, e_fetch(0),        "final_fetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
